// File: rtl/instr_fetch_unit_if.sv
// Bundles the instruction-bus, memory and redirect signals of instr_fetch_unit.
// The master modport is the fetch unit's side; slave is the datapath/memory side.
interface instr_fetch_unit_if;
  logic        PCSRC;
  logic [31:0] BRANCH_TARGET;
  logic        STALL;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA;
  logic        IMEM_VALID;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic [31:0] PC_OUT;
  logic        MISALIGN;

  modport master (
    input  PCSRC, BRANCH_TARGET, STALL, IMEM_RDATA, IMEM_VALID,
    output IMEM_REQ, IMEM_ADDR, INSTRUCTION, INSTR_VALID, PC_OUT, MISALIGN
  );

  modport slave (
    output PCSRC, BRANCH_TARGET, STALL, IMEM_RDATA, IMEM_VALID,
    input  IMEM_REQ, IMEM_ADDR, INSTRUCTION, INSTR_VALID, PC_OUT, MISALIGN
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, single-outstanding memory request, valid/stall presentation.
// Define IFU_MISALIGN_TRAP_EN to trap misaligned redirects into a sticky HALT state.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic                 CLK,
  input logic                 RESET,
  instr_fetch_unit_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
`ifdef IFU_MISALIGN_TRAP_EN
    , S_HALT
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] pcout_q, pcout_d;
  logic        discard_q, discard_d;
  logic        redirect;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
  logic        trap;

  assign redirect      = bus.PCSRC && (state_q != S_HALT);
  assign trap          = redirect && (bus.BRANCH_TARGET[1:0] != 2'b00);
  assign bus.MISALIGN  = misalign_q;
`else
  assign redirect      = bus.PCSRC;
  assign bus.MISALIGN  = 1'b0;
`endif

  assign bus.IMEM_REQ    = (state_q == S_REQ);
  assign bus.IMEM_ADDR   = pc_q;
  assign bus.INSTRUCTION = instr_q;
  assign bus.INSTR_VALID = valid_q;
  assign bus.PC_OUT      = pcout_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    pcout_d   = pcout_q;
    discard_d = discard_q;
`ifdef IFU_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        if (bus.IMEM_VALID) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            instr_d = bus.IMEM_RDATA;
            pcout_d = pc_q;
            pc_d    = pc_q + 32'd4;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!bus.STALL) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = S_REQ;
        end
      end
`ifdef IFU_MISALIGN_TRAP_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides capture/consume decided above; a request already
    // issued (REQ) or still pending (WAIT) must have its response dropped.
    if (redirect) begin
      pc_d    = bus.BRANCH_TARGET & ~32'h3;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      case (state_q)
        S_REQ: begin
          discard_d = 1'b1;
          state_d   = S_WAIT;
        end
        S_WAIT: begin
          if (bus.IMEM_VALID) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            discard_d = 1'b1;
            state_d   = S_WAIT;
          end
        end
        default: state_d = S_REQ;
      endcase
`ifdef IFU_MISALIGN_TRAP_EN
      if (trap) begin
        pc_d       = bus.BRANCH_TARGET;
        misalign_d = 1'b1;
        discard_d  = 1'b0;
        state_d    = S_HALT;
      end
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
      pcout_q   <= RESET_PC;
      discard_q <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      pcout_q   <= pcout_d;
      discard_q <= discard_d;
`ifdef IFU_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

endmodule
